piso_tx: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on a single serial line with a qualifying valid strobe. It is the transmit end of the team's serial-in/parallel-out shift path and sits in front of the `sipo` receiver. Its serial output feeds `sipo`'s serial input directly.

---
 rtl/piso_tx.sv | 78 +++++++
 tb/tb_piso_tx.sv | 116 +++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter feeding the sipo receiver.
//   Optional feature macro: PISO_PARITY_EN appends one even-parity bit per word.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     load_valid din holds a word to send
//     load_ready block accepts a word this cycle
//     din        WIDTH-bit parallel word, captured on handshake
//     out        serial data (0 when idle)
//     out_valid  out carries a data or parity bit
//     busy       a word is in flight
module piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   output logic             out,
   output logic             out_valid,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic par;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif
   state_t state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0] cnt;
   logic last, take, head;
   assign last = state == SHIFT && cnt == LAST;
   assign head = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   assign take = load_valid && load_ready;
   assign busy = state != IDLE;
`ifdef PISO_PARITY_EN
   // the parity cycle takes the place of the last data bit as the reload slot
   assign load_ready = state == IDLE || state == PARITY;
   assign out        = state == SHIFT ? head : state == PARITY ? par : 1'b0;
   assign out_valid  = state == SHIFT || state == PARITY;
`else
   assign load_ready = state == IDLE || last;
   assign out        = state == SHIFT ? head : 1'b0;
   assign out_valid  = state == SHIFT;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (take) begin
         state <= SHIFT;
         sr    <= din;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= ^din;
`endif
      end else if (state == SHIFT) begin
         sr  <= MSB_FIRST ? sr << 1 : sr >> 1;
         cnt <= last ? '0 : cnt + CW'(1);
`ifdef PISO_PARITY_EN
         if (last) state <= PARITY;
`else
         if (last) state <= IDLE;
`endif
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx, MSB-first and LSB-first instances on shared stimulus.
module tb_piso_tx;
   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   logic clk = 0, rst = 0, load_valid = 0;
   logic [W-1:0] din = '0;
   logic rdy0, out0, ov0, busy0, rdy1, out1, ov1, busy1;
   logic q0[$], q1[$];
   int n_chk = 0, n_fail = 0;

   piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut0 (.clk(clk), .rst(rst), .load_valid(load_valid),
      .load_ready(rdy0), .din(din), .out(out0), .out_valid(ov0), .busy(busy0));
   piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut1 (.clk(clk), .rst(rst), .load_valid(load_valid),
      .load_ready(rdy1), .din(din), .out(out1), .out_valid(ov1), .busy(busy1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         q0.push_back(w[W-1-i]);
         q1.push_back(w[i]);
      end
`ifdef PISO_PARITY_EN
      q0.push_back(^w);
      q1.push_back(^w);
`endif
   endtask

   // called just after a falling edge; the handshake happens on the following rising edge
   task automatic send(input logic [W-1:0] w);
      load_valid = 1;
      din = w;
      @(posedge clk);
      #1;
      push(w);
      load_valid = 0;
      din = '0;
   endtask

   // expected ready: idle, or on the final bit of a frame
   always @(negedge clk) if (rst) begin
      chk("ov0", ov0, q0.size() != 0);
      chk("ov1", ov1, q1.size() != 0);
      chk("rdy0", rdy0, q0.size() <= 1);
      chk("rdy1", rdy1, q1.size() <= 1);
      chk("busy0", busy0, q0.size() != 0);
      chk("busy1", busy1, q1.size() != 0);
      chk("out0", out0, q0.size() != 0 ? q0.pop_front() : 1'b0);
      chk("out1", out1, q1.size() != 0 ? q1.pop_front() : 1'b0);
   end

   initial begin
      #2;
      chk("rst_rdy", rdy0, 1);
      chk("rst_out", out0, 0);
      chk("rst_ov", ov0, 0);
      chk("rst_busy", busy0, 0);
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      // single word: MSB 1,0,0,1 and LSB-first instance 1,0,0,1
      send(4'b1001);
      repeat (FL + 3) @(negedge clk);
      // LSB-first pattern: 1101 -> dut1 streams 1,0,1,1
      send(4'b1101);
      repeat (FL + 2) @(negedge clk);
      // back-to-back
      send(4'b1011);
      repeat (FL) @(negedge clk);
      send(4'b0110);
      repeat (FL + 2) @(negedge clk);
      // load_valid during a busy word is ignored until the reload slot
      send(4'b1000);
      repeat (2) @(negedge clk);
      load_valid = 1;
      din = 4'b1111;
      repeat (FL - 2) @(negedge clk);
      send(4'b1111);
      repeat (FL + 2) @(negedge clk);
      send(4'b1001);
      repeat (FL + 2) @(negedge clk);
      // asynchronous reset mid-word
      send(4'b1110);
      repeat (2) @(negedge clk);
      #1 rst = 0;
      #1;
      chk("arst_out", out0, 0);
      chk("arst_ov", ov0, 0);
      chk("arst_rdy", rdy0, 1);
      chk("arst_busy", busy0, 0);
      chk("arst_ov1", ov1, 0);
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      send(4'b0101);
      repeat (FL + 3) @(negedge clk);
      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
